// File: rtl/seg7_scan_decoder.sv
// Recovers a 4-digit hex value by snooping a multiplexed, active-low 7-segment display bus.
// Ports: clk/rst (async high), seg[0:6] a..g, an[3:0] digit enables, sample_en strobe;
//        value/digit_err/valid hold the last frame, frame_done/stale/an_err are one-cycle pulses.
module seg7_scan_decoder #(
   parameter int unsigned MATCH_N = 2,
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [0:6]  seg,
   input  logic [3:0]  an,
   input  logic        sample_en,
   output logic [15:0] value,
   output logic [3:0]  digit_err,
   output logic        valid,
   output logic        frame_done,
   output logic        stale,
   output logic        an_err
);

   typedef enum logic {S_COLLECT, S_PUBLISH} state_e;

   localparam logic [3:0]  RUN_HIT   = 4'(MATCH_N);
   localparam logic [19:0] IDLE_LAST = 20'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [3:0]  last_an_q, last_an_d;
   logic [0:6]  last_seg_q, last_seg_d;
   logic [3:0]  run_q, run_d;
   logic [15:0] stg_nib_q, stg_nib_d;
   logic [3:0]  stg_err_q, stg_err_d;
   logic [3:0]  mask_q, mask_d;
   logic [19:0] idle_q, idle_d;
   logic [15:0] value_q, value_d;
   logic [3:0]  derr_q, derr_d;
   logic        valid_q, valid_d;
   logic        fd_q, fd_d;
   logic        stale_q, stale_d;
   logic        anerr_q, anerr_d;

   logic [0:6]  pix;
   logic [3:0]  dec_nib;
   logic        dec_bad;
   logic [1:0]  dig;
   logic [3:0]  sel_n;
   logic        one_low, multi_low, qual, same, capture;

   assign pix       = ~seg;
   assign sel_n     = ~an;
   // x & (x-1) clears the lowest set bit: zero means at most one digit selected
   assign multi_low = (sel_n & (sel_n - 4'd1)) != 4'd0;
   assign one_low   = (sel_n != 4'd0) && !multi_low;
   assign qual      = sample_en && one_low;
   assign same      = (an == last_an_q) && (seg == last_seg_q);

   always_comb begin
      dec_nib = 4'h0;
      dec_bad = 1'b0;
      case (pix)
         7'b1111110: dec_nib = 4'h0;
         7'b0110000: dec_nib = 4'h1;
         7'b1101101: dec_nib = 4'h2;
         7'b1111001: dec_nib = 4'h3;
         7'b0110011: dec_nib = 4'h4;
         7'b1011011: dec_nib = 4'h5;
         7'b1011111: dec_nib = 4'h6;
         7'b1110000: dec_nib = 4'h7;
         7'b1111111: dec_nib = 4'h8;
         7'b1111011: dec_nib = 4'h9;
         7'b1110111: dec_nib = 4'hA;
         7'b0011111: dec_nib = 4'hB;
         7'b1001110: dec_nib = 4'hC;
         7'b0111101: dec_nib = 4'hD;
         7'b1001111: dec_nib = 4'hE;
         7'b1000111: dec_nib = 4'hF;
         default:    dec_bad = 1'b1;
      endcase
   end

   always_comb begin
      dig = 2'd0;
      case (an)
         4'b1110: dig = 2'd0;
         4'b1101: dig = 2'd1;
         4'b1011: dig = 2'd2;
         4'b0111: dig = 2'd3;
         default: dig = 2'd0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      last_an_d  = last_an_q;
      last_seg_d = last_seg_q;
      run_d      = run_q;
      stg_nib_d  = stg_nib_q;
      stg_err_d  = stg_err_q;
      mask_d     = mask_q;
      idle_d     = idle_q;
      value_d    = value_q;
      derr_d     = derr_q;
      valid_d    = valid_q;
      fd_d       = 1'b0;
      stale_d    = 1'b0;
      anerr_d    = sample_en && multi_low;
      capture    = 1'b0;

      if (qual) begin
         if (same) begin
            if (run_q != 4'hF) run_d = run_q + 4'd1;
         end else begin
            last_an_d  = an;
            last_seg_d = seg;
            run_d      = 4'd1;
         end
         // fire only on the sample that brings the run up to the threshold
         capture = (run_d == RUN_HIT) && (!same || run_d != run_q);
      end

      case (state_q)
         S_COLLECT: begin
            if (mask_q == 4'hF) begin
               state_d = S_PUBLISH;
               value_d = stg_nib_q;
               derr_d  = stg_err_q;
               valid_d = 1'b1;
               fd_d    = 1'b1;
               mask_d  = 4'h0;
            end
         end
         S_PUBLISH: state_d = S_COLLECT;
         default:   state_d = S_COLLECT;
      endcase

      // capture is applied after the publish clear so it counts toward the next frame
      if (capture) begin
         stg_nib_d[{dig, 2'b00} +: 4] = dec_nib;
         stg_err_d[dig] = dec_bad;
         mask_d[dig]    = 1'b1;
         idle_d         = 20'd0;
      end else if (idle_q == IDLE_LAST) begin
         stale_d = 1'b1;
         valid_d = 1'b0;
         mask_d  = 4'h0;
         idle_d  = 20'd0;
      end else begin
         idle_d = idle_q + 20'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_COLLECT;
         last_an_q  <= 4'h0;
         last_seg_q <= 7'h00;
         run_q      <= 4'd0;
         stg_nib_q  <= 16'h0000;
         stg_err_q  <= 4'h0;
         mask_q     <= 4'h0;
         idle_q     <= 20'd0;
         value_q    <= 16'h0000;
         derr_q     <= 4'h0;
         valid_q    <= 1'b0;
         fd_q       <= 1'b0;
         stale_q    <= 1'b0;
         anerr_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_an_q  <= last_an_d;
         last_seg_q <= last_seg_d;
         run_q      <= run_d;
         stg_nib_q  <= stg_nib_d;
         stg_err_q  <= stg_err_d;
         mask_q     <= mask_d;
         idle_q     <= idle_d;
         value_q    <= value_d;
         derr_q     <= derr_d;
         valid_q    <= valid_d;
         fd_q       <= fd_d;
         stale_q    <= stale_d;
         anerr_q    <= anerr_d;
      end
   end

   assign value      = value_q;
   assign digit_err  = derr_q;
   assign valid      = valid_q;
   assign frame_done = fd_q;
   assign stale      = stale_q;
   assign an_err     = anerr_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scans, per-cycle reference model compare,
// plus literal checks of frame values, glitch rejection, an_err, timeout and reset.
module tb_seg7_scan_decoder;

   localparam int MN = 2;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [0:6]  seg_r = 7'h7F;
   logic [3:0]  an_r = 4'hF;
   logic        en_r = 1'b0;
   logic [15:0] value;
   logic [3:0]  digit_err;
   logic        valid, frame_done, stale, an_err;

   int n_tests = 0;
   int n_fail  = 0;
   int fd_cnt  = 0;

   seg7_scan_decoder #(.MATCH_N(MN), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .seg(seg_r), .an(an_r), .sample_en(en_r),
      .value(value), .digit_err(digit_err), .valid(valid),
      .frame_done(frame_done), .stale(stale), .an_err(an_err)
   );

   always #5 clk = ~clk;

   // lit segments a..g per hex digit
   logic [0:6] pat [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

   // ---------------- reference model ----------------
   logic [15:0] m_val;
   logic [3:0]  m_err, m_have, m_serr;
   logic        m_valid, m_fd, m_stale, m_anerr;
   logic [3:0]  m_stg [4];
   logic [3:0]  m_prev_an;
   logic [0:6]  m_prev_seg;
   bit          m_prev_ok, m_done_run, m_cap;
   int          m_run, m_idle, m_lows, m_d, m_nib;
   bit          m_bad;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_val = '0; m_err = '0; m_valid = 0; m_fd = 0; m_stale = 0; m_anerr = 0;
         m_have = '0; m_serr = '0; m_prev_ok = 0; m_done_run = 0;
         m_run = 0; m_idle = 0;
         for (int i = 0; i < 4; i++) m_stg[i] = '0;
      end else begin
         m_fd = 0; m_stale = 0; m_anerr = 0; m_cap = 0;
         m_lows = 0;
         for (int i = 0; i < 4; i++) if (an_r[i] == 1'b0) m_lows++;
         if (en_r && m_lows > 1) m_anerr = 1;
         if (en_r && m_lows == 1) begin
            if (m_prev_ok && an_r == m_prev_an && seg_r == m_prev_seg) begin
               if (m_run < 15) m_run++;
            end else begin
               m_prev_ok = 1; m_prev_an = an_r; m_prev_seg = seg_r;
               m_run = 1; m_done_run = 0;
            end
            if (!m_done_run && m_run >= MN) begin
               m_cap = 1; m_done_run = 1;
            end
         end
         if (m_have == 4'hF) begin
            m_val = {m_stg[3], m_stg[2], m_stg[1], m_stg[0]};
            m_err = m_serr; m_valid = 1; m_fd = 1; m_have = '0;
         end
         if (m_cap) begin
            for (int i = 0; i < 4; i++) if (an_r[i] == 1'b0) m_d = i;
            m_nib = 0; m_bad = 1;
            for (int k = 0; k < 16; k++)
               if (pat[k] == ~seg_r) begin m_nib = k; m_bad = 0; end
            m_stg[m_d] = 4'(m_nib); m_serr[m_d] = m_bad; m_have[m_d] = 1'b1;
            m_idle = 0;
         end else if (m_idle + 1 == TO) begin
            m_stale = 1; m_valid = 0; m_have = '0; m_idle = 0;
         end else begin
            m_idle++;
         end
      end
   end

   always @(negedge clk) begin
      n_tests++;
      if ({value, digit_err, valid, frame_done, stale, an_err} !==
          {m_val, m_err, m_valid, m_fd, m_stale, m_anerr}) begin
         n_fail++;
         $display("FAIL cycle@%0t: got v=%h e=%b val=%b fd=%b st=%b ae=%b, expected v=%h e=%b val=%b fd=%b st=%b ae=%b",
                  $time, value, digit_err, valid, frame_done, stale, an_err,
                  m_val, m_err, m_valid, m_fd, m_stale, m_anerr);
      end
      if (frame_done === 1'b1) fd_cnt++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic [0:6] s, input logic [3:0] a, input logic e);
      @(posedge clk);
      #2;
      seg_r = s; an_r = a; en_r = e;
   endtask

   task automatic hold(input logic [0:6] s, input int d, input int k);
      logic [3:0] a;
      a = ~(4'b0001 << d);
      repeat (k) cyc(s, a, 1'b1);
   endtask

   function automatic logic [0:6] enc(input int n);
      return ~pat[n];
   endfunction

   task automatic scan4(input int n3, input int n2, input int n1, input int n0);
      hold(enc(n3), 3, 2);
      hold(enc(n2), 2, 2);
      hold(enc(n1), 1, 2);
      hold(enc(n0), 0, 2);
   endtask

   task automatic wait_fd(input string nm);
      bit got;
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         cyc(7'h7F, 4'hF, 1'b0);
         @(negedge clk);
         got = frame_done;
      end
      chk(nm, 32'(got), 32'd1);
   endtask

   initial begin
      int cnt, fd0;
      bit got;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_value", 32'(value), 32'h0);
      chk("reset_valid", 32'(valid), 32'h0);
      chk("reset_fd", 32'(frame_done), 32'h0);
      @(posedge clk);
      #2 rst = 1'b0;

      scan4(1, 2, 3, 4);
      wait_fd("fd_1234");
      chk("value_1234", 32'(value), 32'h1234);
      chk("err_1234", 32'(digit_err), 32'h0);
      chk("valid_1234", 32'(valid), 32'h1);

      hold(enc(10), 3, 2);
      hold(enc(11), 2, 2);
      hold(enc(12), 1, 2);
      hold(7'h7F, 0, 2);
      wait_fd("fd_abc0");
      chk("value_abc0", 32'(value), 32'hABC0);
      chk("err_abc0", 32'(digit_err), 32'h1);

      hold(enc(1), 3, 2);
      hold(enc(5), 2, 2);
      hold(enc(8), 2, 1);
      hold(enc(5), 2, 2);
      hold(enc(3), 1, 2);
      hold(enc(4), 0, 2);
      wait_fd("fd_glitch");
      chk("value_glitch", 32'(value), 32'h1534);

      hold(enc(9), 3, 1);
      cyc(enc(9), 4'b0011, 1'b1);
      hold(enc(9), 3, 1);
      @(negedge clk);
      chk("an_err_pulse", 32'(an_err), 32'h1);
      hold(enc(8), 2, 1);
      @(negedge clk);
      chk("an_err_once", 32'(an_err), 32'h0);
      hold(enc(8), 2, 1);
      hold(enc(7), 1, 2);
      hold(enc(6), 0, 2);
      wait_fd("fd_9876");
      chk("value_9876", 32'(value), 32'h9876);

      scan4(11, 14, 14, 15);
      wait_fd("fd_beef");
      chk("value_beef", 32'(value), 32'hBEEF);
      cnt = 0; got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         cyc(7'h7F, 4'hF, 1'b0);
         @(negedge clk);
         cnt++;
         got = stale;
      end
      chk("stale_seen", 32'(got), 32'h1);
      chk("stale_delay", 32'(cnt), 32'd15);
      chk("stale_valid", 32'(valid), 32'h0);
      chk("stale_value", 32'(value), 32'hBEEF);

      fd0 = fd_cnt;
      hold(enc(3), 2, 2);
      hold(enc(2), 1, 2);
      hold(enc(1), 0, 2);
      cyc(7'h7F, 4'hF, 1'b0);
      rst = 1'b1;
      cyc(7'h7F, 4'hF, 1'b0);
      cyc(7'h7F, 4'hF, 1'b0);
      rst = 1'b0;
      scan4(1, 2, 3, 4);
      chk("no_early_fd", 32'(fd_cnt - fd0), 32'd0);
      wait_fd("fd_after_rst");
      chk("value_after_rst", 32'(value), 32'h1234);

      repeat (3) cyc(7'h7F, 4'hF, 1'b0);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter MATCH_N, default 2: number of consecutive identical qualified samples required to capture a digit (legal range 1..15).
REQ-002 Parameter TIMEOUT, default 65535: number of clk cycles without a capture before the output is declared stale (legal range 1..2^20-1).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 seg  input  [0:6]  active-low segment bus; seg[0]=a ... seg[6]=g.
REQ-006 an  input  [3:0]  active-low digit enables; an[i]=0 selects digit i, and digit 3 is the most significant.
REQ-007 sample_en  input  1  sample strobe; seg/an are examined only in cycles where it is high.
REQ-008 value  output  [15:0]  last published frame; nibble i = digit i.
REQ-009 digit_err  output  [3:0]  bit i set when digit i of the published frame held an undecodable pattern.
REQ-010 valid  output  1  value/digit_err hold a non-stale frame.
REQ-011 frame_done  output  1  one-cycle pulse on each publish.
REQ-012 stale  output  1  one-cycle pulse when the timeout fires.
REQ-013 an_err  output  1  one-cycle pulse, registered, on a sampled cycle with more than one an bit low.

Function
REQ-014 A sample SHALL be qualified when sample_en=1 and exactly one bit of an is 0; a sample with all an bits 1 SHALL be ignored silently, and a sample with two or more an bits 0 SHALL be ignored and SHALL raise an_err.
REQ-015 Decoding SHALL operate on p=~seg, and the p[0:6] (a..g) patterns SHALL map as follows: 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9, 1110111->A, 0011111->B, 1001110->C, 0111101->D, 1001111->E, 1000111->F.
REQ-016 Any other pattern, including all-off, SHALL decode to nibble 0 with the error flag set.
REQ-017 A run tracker SHALL hold last_an, last_seg, and a saturating run count; on a qualified sample that equals (last_an,last_seg) the count SHALL increment, otherwise the tracker SHALL reload with the new pair and count=1.
REQ-018 When the run count becomes equal to MATCH_N, the digit SHALL be captured exactly once per run: the staged nibble and error are written for the selected digit and its bit is set in collect_mask.
REQ-019 Re-capturing a digit already in collect_mask SHALL overwrite its staged nibble and error.
REQ-020 The FSM SHALL have two states, COLLECT and PUBLISH.
REQ-021 In COLLECT, when collect_mask==4'b1111 at a clock edge, the FSM SHALL move to PUBLISH.
REQ-022 PUBLISH SHALL last one cycle, during which value<=staged nibbles, digit_err<=staged errors, valid<=1, frame_done=1, collect_mask cleared, and the FSM returns to COLLECT.
REQ-023 A capture occurring in the PUBLISH cycle SHALL survive the mask clear and count toward the next frame.
REQ-024 Publish latency SHALL be 2 cycles: a capture completing the mask on edge N gives frame_done high in cycle N+1 and the new value visible after edge N+1.
REQ-025 An idle counter SHALL reset on every capture and otherwise increment; on reaching TIMEOUT it SHALL pulse stale, clear valid and collect_mask, reload to 0, and leave value and digit_err unchanged.
REQ-026 If timeout and a capture coincide, the capture SHALL win and no stale pulse SHALL occur.
REQ-027 All outputs SHALL be registered, with no combinational path from the inputs.

Reset
REQ-028 While rst=1, value=0, digit_err=0, valid=0, frame_done=0, stale=0, an_err=0, collect_mask=0, run count=0, idle counter=0, and the FSM=COLLECT.
REQ-029 Reset asserted mid-frame SHALL discard all staged digits, and the first frame after release SHALL require four fresh captures.

Verification
REQ-030 Scan digits 3..0 with patterns 1/2/3/4 (seg=~0110000 etc.), each held 2 samples, MATCH_N=2 -> frame_done pulse, value=16'h1234, digit_err=0, valid=1.
REQ-031 Digit 0 is driven with an all-off pattern (seg=7'h7F) and digits 3..1 with A, B, C -> value=16'hABC0, digit_err=4'b0001.
REQ-032 A one-sample glitch pattern 8 is inserted on digit 2 between two valid runs of 5 -> the glitch is not captured and the nibble for digit 2 is 5.
REQ-033 A sample with an=4'b0011 -> an_err pulses once, and collect_mask and the tracker are unchanged.
REQ-034 With TIMEOUT=16, captures stop after a publish of 16'hBEEF -> stale pulses 16 cycles after the last capture, valid=0, value stays 16'hBEEF.
REQ-035 rst is asserted after three digits are captured, then the same scan resumes -> no frame_done until all four digits are recaptured.
